// File: rtl/mul_issue_arbiter.sv
// Round-robin arbiter that shares one multi-cycle signed multiplier between two issue slots.
// Accepted ops are captured, counted down over MUL_LAT cycles and returned with tag and source slot.
module mul_issue_arbiter #(
    parameter int DATA_W  = 16,
    parameter int TAG_W   = 4,
    parameter int MUL_LAT = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_vld_in,
    input  logic [DATA_W-1:0] req0_rs_in,
    input  logic [DATA_W-1:0] req0_rt_in,
    input  logic [TAG_W-1:0]  req0_tag_in,
    output logic              req0_rdy_out,
    input  logic              req1_vld_in,
    input  logic [DATA_W-1:0] req1_rs_in,
    input  logic [DATA_W-1:0] req1_rt_in,
    input  logic [TAG_W-1:0]  req1_tag_in,
    output logic              req1_rdy_out,
    input  logic              flush_in,
    output logic              res_vld_out,
    output logic [DATA_W-1:0] res_data_out,
    output logic [TAG_W-1:0]  res_tag_out,
    output logic              res_src_out,
    output logic              busy_out
);
    // state | meaning
    // IDLE  | no op in flight
    // EXEC  | multiply in progress, cnt counts down to 0
    // DONE  | result presented for exactly one cycle
    typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, DONE = 2'd2} state_t;

    localparam logic [3:0] CNT_INIT = 4'(MUL_LAT - 2);

    state_t            state;
    state_t            state_nxt;
    logic [3:0]        cnt;
    logic [3:0]        cnt_nxt;
    logic              ptr;
    logic [DATA_W-1:0] cap_rs;
    logic [DATA_W-1:0] cap_rt;
    logic [TAG_W-1:0]  cap_tag;
    logic              cap_src;
    logic [DATA_W-1:0] prod_lo;
    logic              can_acc;
    logic              grant0;
    logic              grant1;
    logic              acc;
    logic              finish;

    assign can_acc = (state != EXEC) & ~flush_in;
    assign grant0  = req0_vld_in & (~req1_vld_in | ~ptr);
    assign grant1  = req1_vld_in & (~req0_vld_in | ptr);
    assign acc     = can_acc & (grant0 | grant1);
    assign finish  = (state == EXEC) & ~flush_in & (cnt == 4'd0);

    // Low DATA_W bits of a two's-complement product equal those of the unsigned product.
    assign prod_lo = cap_rs * cap_rt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (acc) begin
                    state_nxt = EXEC;
                    cnt_nxt   = CNT_INIT;
                end
            end
            EXEC: begin
                if (flush_in) begin
                    state_nxt = IDLE;
                    cnt_nxt   = 4'd0;
                end else if (cnt == 4'd0) begin
                    state_nxt = DONE;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            DONE: begin
                if (acc) begin
                    state_nxt = EXEC;
                    cnt_nxt   = CNT_INIT;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = 4'd0;
            end
        endcase
    end

    always_comb begin
        req0_rdy_out = can_acc & grant0;
        req1_rdy_out = can_acc & grant1;
        res_vld_out  = (state == DONE);
        busy_out     = (state == EXEC);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr     <= 1'b0;
            cap_rs  <= '0;
            cap_rt  <= '0;
            cap_tag <= '0;
            cap_src <= 1'b0;
        end else if (acc) begin
            ptr     <= grant0;
            cap_rs  <= grant0 ? req0_rs_in  : req1_rs_in;
            cap_rt  <= grant0 ? req0_rt_in  : req1_rt_in;
            cap_tag <= grant0 ? req0_tag_in : req1_tag_in;
            cap_src <= grant1;
        end
    end

    // Result registers only move on the EXEC->DONE transition so they hold between pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_data_out <= '0;
            res_tag_out  <= '0;
            res_src_out  <= 1'b0;
        end else if (finish) begin
            res_data_out <= prod_lo;
            res_tag_out  <= cap_tag;
            res_src_out  <= cap_src;
        end
    end

endmodule

// File: tb/tb_mul_issue_arbiter.sv
// Directed vector bench for mul_issue_arbiter: a MUL_LAT=3 instance and a MUL_LAT=2 instance
// share the stimulus; each table section is compared against the instance it targets.
module tb_mul_issue_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        v0 = 1'b0, v1 = 1'b0, fl = 1'b0;
    logic [15:0] rs0 = '0, rt0 = '0, rs1 = '0, rt1 = '0;
    logic [3:0]  tg0 = '0, tg1 = '0;

    logic        a_r0, a_r1, a_vld, a_src, a_busy;
    logic [15:0] a_data;
    logic [3:0]  a_tag;
    logic        b_r0, b_r1, b_vld, b_src, b_busy;
    logic [15:0] b_data;
    logic [3:0]  b_tag;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mul_issue_arbiter #(.DATA_W(16), .TAG_W(4), .MUL_LAT(3)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .req0_vld_in(v0), .req0_rs_in(rs0), .req0_rt_in(rt0), .req0_tag_in(tg0), .req0_rdy_out(a_r0),
        .req1_vld_in(v1), .req1_rs_in(rs1), .req1_rt_in(rt1), .req1_tag_in(tg1), .req1_rdy_out(a_r1),
        .flush_in(fl), .res_vld_out(a_vld), .res_data_out(a_data), .res_tag_out(a_tag),
        .res_src_out(a_src), .busy_out(a_busy));

    mul_issue_arbiter #(.DATA_W(16), .TAG_W(4), .MUL_LAT(2)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .req0_vld_in(v0), .req0_rs_in(rs0), .req0_rt_in(rt0), .req0_tag_in(tg0), .req0_rdy_out(b_r0),
        .req1_vld_in(v1), .req1_rs_in(rs1), .req1_rt_in(rt1), .req1_tag_in(tg1), .req1_rdy_out(b_r1),
        .flush_in(fl), .res_vld_out(b_vld), .res_data_out(b_data), .res_tag_out(b_tag),
        .res_src_out(b_src), .busy_out(b_busy));

    typedef struct {
        string       nm;
        logic        sel;
        logic        rst;
        logic        v0;
        logic [15:0] rs0, rt0;
        logic [3:0]  tg0;
        logic        v1;
        logic [15:0] rs1, rt1;
        logic [3:0]  tg1;
        logic        fl;
        logic        r0, r1, vld;
        logic [15:0] data;
        logic [3:0]  tag;
        logic        src, busy;
    } vec_t;

    vec_t vq[$];
    string cur_nm;
    logic  cur_sel;

    function automatic void add(input logic rst,
                                input logic iv0, input logic [15:0] irs0, input logic [15:0] irt0, input logic [3:0] itg0,
                                input logic iv1, input logic [15:0] irs1, input logic [15:0] irt1, input logic [3:0] itg1,
                                input logic ifl, input logic er0, input logic er1, input logic evld,
                                input logic [15:0] edata, input logic [3:0] etag, input logic esrc, input logic ebusy);
        vec_t t;
        t.nm = cur_nm; t.sel = cur_sel; t.rst = rst;
        t.v0 = iv0; t.rs0 = irs0; t.rt0 = irt0; t.tg0 = itg0;
        t.v1 = iv1; t.rs1 = irs1; t.rt1 = irt1; t.tg1 = itg1;
        t.fl = ifl; t.r0 = er0; t.r1 = er1; t.vld = evld;
        t.data = edata; t.tag = etag; t.src = esrc; t.busy = ebusy;
        vq.push_back(t);
    endfunction

    // Entered and left at posedge+1.
    task automatic do_reset();
        logic bad;
        rst_n = 1'b0;
        v0 = 0; v1 = 0; fl = 0;
        @(negedge clk);
        vectors++;
        bad = (a_vld | a_busy | a_src | b_vld | b_busy | b_src) || (a_data != 16'h0) || (a_tag != 4'h0) ||
              (b_data != 16'h0) || (b_tag != 4'h0);
        if (bad) begin
            miscompares++;
            $display("FAIL reset_state: a vld=%b busy=%b data=%h tag=%h src=%b b vld=%b busy=%b data=%h tag=%h src=%b, required all zero",
                     a_vld, a_busy, a_data, a_tag, a_src, b_vld, b_busy, b_data, b_tag, b_src);
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input vec_t t, input int idx);
        logic        r0, r1, vld, src, busy, bad;
        logic [15:0] data;
        logic [3:0]  tag;
        if (t.rst) do_reset();
        v0 = t.v0; rs0 = t.rs0; rt0 = t.rt0; tg0 = t.tg0;
        v1 = t.v1; rs1 = t.rs1; rt1 = t.rt1; tg1 = t.tg1;
        fl = t.fl;
        @(negedge clk);
        r0   = t.sel ? b_r0   : a_r0;
        r1   = t.sel ? b_r1   : a_r1;
        vld  = t.sel ? b_vld  : a_vld;
        busy = t.sel ? b_busy : a_busy;
        data = t.sel ? b_data : a_data;
        tag  = t.sel ? b_tag  : a_tag;
        src  = t.sel ? b_src  : a_src;
        bad = (r0 != t.r0) || (r1 != t.r1) || (vld != t.vld) || (busy != t.busy);
        if (t.vld) bad = bad || (data != t.data) || (tag != t.tag) || (src != t.src);
        vectors++;
        if (bad) begin
            miscompares++;
            $display("FAIL %s #%0d: got rdy=%b%b vld=%b data=%h tag=%h src=%b busy=%b, want rdy=%b%b vld=%b data=%h tag=%h src=%b busy=%b",
                     t.nm, idx, r0, r1, vld, data, tag, src, busy, t.r0, t.r1, t.vld, t.data, t.tag, t.src, t.busy);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check1(input string nm, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %h, want %h", nm, got, want);
        end
    endtask

    initial begin
        cur_sel = 1'b0;
        cur_nm = "single";
        add(1, 0,0,0,0,       0,0,0,0, 0, 0,0,0, 0,0,0, 0);
        add(0, 0,0,0,0,       0,0,0,0, 0, 0,0,0, 0,0,0, 0);
        add(0, 1,16'd7,16'hFFFD,4'd5, 0,0,0,0, 0, 1,0,0, 0,0,0, 0);
        add(0, 0,0,0,0,       0,0,0,0, 0, 0,0,0, 0,0,0, 1);
        add(0, 0,0,0,0,       0,0,0,0, 0, 0,0,0, 0,0,0, 1);
        add(0, 0,0,0,0,       0,0,0,0, 0, 0,0,1, 16'hFFEB,4'd5,0, 0);
        add(0, 0,0,0,0,       0,0,0,0, 0, 0,0,0, 0,0,0, 0);

        cur_nm = "contention";
        add(1, 1,16'd3,16'd5,4'd1, 1,16'hFFFE,16'd9,4'd2, 0, 1,0,0, 0,0,0, 0);
        for (int k = 1; k <= 11; k++) begin
            case (k % 6)
                0:       add(0, 1,16'd3,16'd5,4'd1, 1,16'hFFFE,16'd9,4'd2, 0, 1,0,1, 16'hFFEE,4'd2,1, 0);
                3:       add(0, 1,16'd3,16'd5,4'd1, 1,16'hFFFE,16'd9,4'd2, 0, 0,1,1, 16'h000F,4'd1,0, 0);
                default: add(0, 1,16'd3,16'd5,4'd1, 1,16'hFFFE,16'd9,4'd2, 0, 0,0,0, 0,0,0, 1);
            endcase
        end
        add(0, 0,0,0,0, 0,0,0,0, 0, 0,0,1, 16'hFFEE,4'd2,1, 0);
        add(0, 0,0,0,0, 0,0,0,0, 0, 0,0,0, 0,0,0, 0);

        cur_nm = "truncate";
        add(0, 0,0,0,0, 1,16'h4000,16'd4,4'd3, 0, 0,1,0, 0,0,0, 0);
        add(0, 0,0,0,0, 0,0,0,0, 0, 0,0,0, 0,0,0, 1);
        add(0, 0,0,0,0, 0,0,0,0, 0, 0,0,0, 0,0,0, 1);
        add(0, 1,16'h7FFF,16'h7FFF,4'hE, 0,0,0,0, 0, 1,0,1, 16'h0000,4'd3,1, 0);
        add(0, 0,0,0,0, 0,0,0,0, 0, 0,0,0, 0,0,0, 1);
        add(0, 0,0,0,0, 0,0,0,0, 0, 0,0,0, 0,0,0, 1);
        add(0, 0,0,0,0, 0,0,0,0, 0, 0,0,1, 16'h0001,4'hE,0, 0);

        cur_nm = "flush";
        add(0, 1,16'd2,16'd3,4'd4, 0,0,0,0, 1, 0,0,0, 0,0,0, 0);
        add(0, 1,16'd2,16'd3,4'd4, 0,0,0,0, 0, 1,0,0, 0,0,0, 0);
        add(0, 0,0,0,0, 0,0,0,0, 1, 0,0,0, 0,0,0, 1);
        add(0, 0,0,0,0, 1,16'd5,16'hFFFF,4'd6, 0, 0,1,0, 0,0,0, 0);
        add(0, 0,0,0,0, 0,0,0,0, 0, 0,0,0, 0,0,0, 1);
        add(0, 0,0,0,0, 0,0,0,0, 0, 0,0,0, 0,0,0, 1);
        add(0, 1,16'd1,16'd1,4'd7, 0,0,0,0, 1, 0,0,1, 16'hFFFB,4'd6,1, 0);
        add(0, 1,16'd1,16'd1,4'd7, 0,0,0,0, 0, 1,0,0, 0,0,0, 0);
        add(0, 0,0,0,0, 0,0,0,0, 0, 0,0,0, 0,0,0, 1);
        add(0, 0,0,0,0, 0,0,0,0, 0, 0,0,0, 0,0,0, 1);
        add(0, 0,0,0,0, 0,0,0,0, 0, 0,0,1, 16'h0001,4'd7,0, 0);

        foreach (vq[i]) apply(vq[i], i);

        // Asynchronous reset in the middle of EXEC; pointer is 1 here (slot0 accepted last).
        v0 = 1; rs0 = 16'h0010; rt0 = 16'h0010; tg0 = 4'd9; v1 = 0; fl = 0;
        @(negedge clk);
        check1("midrst_accept", {31'd0, a_r0}, 32'd1);
        @(posedge clk);
        #1;
        v0 = 0;
        #1;
        check1("midrst_busy_before", {31'd0, a_busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check1("midrst_outputs_zero", {a_vld, a_busy, a_src, a_tag, a_data}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check1("midrst_no_stale", {30'd0, a_vld, a_busy}, 32'd0);
            @(posedge clk);
            #1;
        end
        vq.delete();
        cur_nm = "post_reset";
        add(0, 1,16'd6,16'd7,4'hA, 1,16'd9,16'd9,4'd1, 0, 1,0,0, 0,0,0, 0);
        add(0, 0,0,0,0, 0,0,0,0, 0, 0,0,0, 0,0,0, 1);
        add(0, 0,0,0,0, 0,0,0,0, 0, 0,0,0, 0,0,0, 1);
        add(0, 0,0,0,0, 0,0,0,0, 0, 0,0,1, 16'h002A,4'hA,0, 0);

        cur_sel = 1'b1;
        cur_nm = "lat2";
        add(1, 1,16'd2,16'd3,4'd1, 1,16'hFFFC,16'd5,4'd2, 0, 1,0,0, 0,0,0, 0);
        add(0, 1,16'd2,16'd3,4'd1, 1,16'hFFFC,16'd5,4'd2, 0, 0,0,0, 0,0,0, 1);
        add(0, 1,16'd2,16'd3,4'd1, 1,16'hFFFC,16'd5,4'd2, 0, 0,1,1, 16'h0006,4'd1,0, 0);
        add(0, 1,16'd2,16'd3,4'd1, 1,16'hFFFC,16'd5,4'd2, 0, 0,0,0, 0,0,0, 1);
        add(0, 1,16'd2,16'd3,4'd1, 1,16'hFFFC,16'd5,4'd2, 0, 1,0,1, 16'hFFEC,4'd2,1, 0);
        add(0, 1,16'd2,16'd3,4'd1, 1,16'hFFFC,16'd5,4'd2, 0, 0,0,0, 0,0,0, 1);
        add(0, 0,0,0,0, 0,0,0,0, 0, 0,0,1, 16'h0006,4'd1,0, 0);
        add(0, 0,0,0,0, 0,0,0,0, 0, 0,0,0, 0,0,0, 0);

        foreach (vq[i]) apply(vq[i], i);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mul_issue_arbiter.md
Name: mul_issue_arbiter

Overview:
- Shares one multi-cycle multiplier between two issue slots.
- Each slot presents a decoded MUL op whose mult-routing flag is set: operands, destination tag and a valid.
- The block picks one slot round-robin, captures its operands, and sequences the multiply over MUL_LAT cycles.
- It returns the product with its tag and source slot to writeback. It sits between decode/issue and the register-write stage.

Parameters:
- DATA_W, 16: operand and result width.
- TAG_W, 4: destination register tag width.
- MUL_LAT, 3: cycles from accept to result; legal range 2..15.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req0_vld_in  in  1  slot 0 has a MUL op
- req0_rs_in  in  DATA_W  slot 0 operand A
- req0_rt_in  in  DATA_W  slot 0 operand B
- req0_tag_in  in  TAG_W  slot 0 destination tag
- req0_rdy_out  out  1  slot 0 accepted this cycle
- req1_vld_in, req1_rs_in, req1_rt_in, req1_tag_in, req1_rdy_out  same as slot 0, for slot 1
- flush_in  in  1  pipeline flush (branch mispredict)
- res_vld_out  out  1  result valid, one-cycle pulse
- res_data_out  out  DATA_W  low DATA_W bits of signed product
- res_tag_out  out  TAG_W  tag of the completed op
- res_src_out  out  1  slot that issued the completed op
- busy_out  out  1  multiplier occupied (state EXEC)

Behaviour:
- States:
  - IDLE: no op in flight.
  - EXEC: multiply in progress; down-counter cnt of 4 bits.
  - DONE: result presented for exactly one cycle.
- Acceptance is allowed when state is IDLE or DONE and flush_in=0 ("can_acc").
- Grant (combinational):
  - If only one slot is valid, it is granted.
  - If both are valid, the slot selected by the priority pointer ptr is granted.
  - reqN_rdy_out = can_acc & grantN. At most one rdy is high; rdy is never high without the matching vld.
- On an accept edge:
  - Capture rs, rt, tag and source slot.
  - Set ptr to the other slot (the one not granted).
  - Move to EXEC with cnt = MUL_LAT-2.
- EXEC:
  - If cnt==0, go to DONE; else decrement cnt.
  - The result of an op accepted at cycle N is valid during cycle N+MUL_LAT.
- DONE:
  - res_vld_out=1; res_data/tag/src hold the op's values.
  - If a new accept occurs in the same cycle, go to EXEC; otherwise go to IDLE.
  - Back-to-back issue therefore gives one result every MUL_LAT cycles.
- res_data/res_tag/res_src are registered. They hold their last value when res_vld_out=0 and change only when entering DONE.
- Arithmetic:
  - Signed two's-complement DATA_W x DATA_W multiply, truncated to the low DATA_W bits.
  - No overflow flag.
  - Operands are taken from the capture registers, not the live inputs.
- flush_in:
  - In EXEC: the next state is IDLE, cnt is cleared, and no result is produced.
  - In DONE: the result pulse is still delivered, since the op is already complete, but there is no accept that cycle; the next state is IDLE.
  - In IDLE: blocks acceptance.
  - ptr is unchanged by flush.
- A vld dropping without an accept is legal. A slot's inputs are only sampled on its accept edge.
- busy_out = (state==EXEC).
- Reset, asynchronous at any time including mid-EXEC:
  - state=IDLE, cnt=0, ptr=0.
  - res_vld_out=0, res_data_out=0, res_tag_out=0, res_src_out=0, busy_out=0.
  - An in-flight op is discarded.

Test Plan:
- Single issue: reset, then slot0 vld with rs=7, rt=-3, tag=5 at cycle 2.
  - req0_rdy_out=1 in cycle 2.
  - res_vld_out=1 only in cycle 5, with data=0xFFEB, tag=5, src=0.
  - busy_out high in cycles 3–4.
- Contention: both slots valid continuously from reset with distinct operands.
  - Grants alternate 0,1,0,1.
  - Accepts land in cycles 0,3,6,9 (back-to-back from DONE).
  - One result every 3 cycles with matching src/tag.
- Overflow truncation: rs=0x4000, rt=4 -> res_data_out=0x0000. rs=0x7FFF, rt=0x7FFF -> 0x0001.
- Flush: flush_in pulsed in the cycle after accept.
  - No res_vld_out pulse; state returns to IDLE.
  - A new request the following cycle is accepted, and its result arrives MUL_LAT cycles later.
  - Flush during DONE still delivers that result and blocks the same-cycle accept.
- Reset mid-op: rst_n low for 1 cycle during EXEC.
  - All outputs go to zero immediately (asynchronous).
  - No stale result afterwards; ptr=0, so slot0 wins the first contention.
- MUL_LAT=2 build: accept in cycle N gives result in cycle N+2. Sustained contention gives a result every 2 cycles.
